dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised RV32I data memory with a valid/ready request port, a registered single-beat response, and a configurable wait-state count. It supports byte, halfword and word stores and sign- or zero-extending loads. Per-word written flags make never-written locations read as zero after reset. It sits in the MEM stage; the hazard unit stalls the pipeline on `req_ready` low or a missing `rsp_valid`.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 0: extra cycles between acceptance and response, 0..15.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request can be accepted this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned; only the low 8/16/32 bits are used.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  load result, extended to 32 bits.
- `rsp_fault`  out  1  misaligned or illegal request; valid with `rsp_valid`.

## Operation
- FSM has three states:
  - IDLE: `req_ready`=1. An accepted request moves to WAIT when `WAIT_STATES`>0, else to RESP.
  - WAIT: `req_ready`=0. A counter loads `WAIT_STATES`-1 and decrements; at 0 the FSM moves to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=1. An accept in RESP goes to WAIT or RESP exactly as from IDLE; no accept returns to IDLE.
- Acceptance is `req_valid && req_ready`. All request fields are latched at acceptance and the inputs may change afterwards.
- The access (array write or read) happens on the clock edge that enters RESP, using the latched fields. With `WAIT_STATES`=0 this is the acceptance edge.
- Word index is `addr[2 +: log2(DEPTH_WORDS)]`. Higher address bits are ignored, so addresses alias with wrap-around. Byte lane is `addr[1:0]`.
- Fault conditions:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 ∉ {000, 001, 010}.
- A faulting request does not write and does not change written flags. It returns `rsp_rdata`=0 and `rsp_fault`=1.
- Store: merged word = (written ? stored word : 0) with the selected byte lanes replaced by `req_wdata` low bytes. The merged word is written and the written flag is set. Unwritten bytes therefore read 0, with no X propagation.
- Load: source word = written ? array word : 0. Select the lane, then LB/LH sign-extend and LBU/LHU zero-extend.
- Store responses return `rsp_rdata`=0 and `rsp_fault`=0.
- The array is not reset. Written flags (DEPTH_WORDS bits) clear on reset, so the entire memory reads 0 after any reset.

## Timing
- Latency from acceptance edge to `rsp_valid` is `WAIT_STATES`+1 cycles.
- Throughput is one request every `WAIT_STATES`+1 cycles; with 0 wait states it is back-to-back, one per cycle.
- Read-after-write: a store accepted at edge E commits at its RESP-entry edge. A load accepted later reads the updated data, with no forwarding needed.
- `rsp_rdata` and `rsp_fault` hold their last values while `rsp_valid` is low.
- Reset values, asserted while `rst_n` is low and immediately on assertion:
  - state IDLE;
  - `req_ready`=0, which rises the first cycle after deassertion;
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0;
  - wait counter 0;
  - all written flags 0.
- Reset mid-operation aborts the in-flight request with no response. A store still in WAIT is never committed.
- A `req_valid` low during RESP returns the FSM to IDLE with no effect on other state.

## Test plan
- **Reset read-zero:** reset, then LW at 0x000, 0x7FC and 0xFFFC → each `rsp_rdata`=0, `rsp_fault`=0, one cycle after accept (`WAIT_STATES`=0).
- **Sub-word merge:** SW 0x11223344 @0x10, SB 0xAA @0x11, SH 0xBEEF @0x16 (first write to that word) → LW @0x10 = 0x1122AA44; LW @0x14 = 0xBEEF0000; LB @0x11 = 0xFFFFFFAA; LBU @0x11 = 0x000000AA; LH @0x16 = 0xFFFFBEEF.
- **Faults:** LW @0x02, SH @0x05, load funct3=011 → `rsp_fault`=1 and `rsp_rdata`=0. A following LW @0x04 returns its prior contents unchanged.
- **Wait states and throughput:** `WAIT_STATES`=3 with `req_valid` held high for 4 loads → `rsp_valid` 4 cycles after each accept; `req_ready` low for exactly 3 cycles per request. With `WAIT_STATES`=0, 4 back-to-back requests give 4 consecutive `rsp_valid` cycles.
- **Aliasing:** `DEPTH_WORDS`=4096, SW 0xCAFEF00D @0x4000 → LW @0x0000 returns 0xCAFEF00D.
- **Reset mid-operation:** `WAIT_STATES`=3, SW 0x12345678 @0x20, assert `rst_n` low 1 cycle after accept → no `rsp_valid`; after release, LW @0x20 = 0. Also write @0x24, reset, and LW @0x24 = 0.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Request/response bundle between the MEM stage and dmem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module      : dmem_ctrl
// Description : RV32I data memory, valid/ready request, registered response,
//               configurable wait states, per-word written flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input wire logic    clk,
    input wire logic    rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state, w_next_state;
    logic [3:0]          r_cnt, w_cnt_next;
    logic                r_live;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [c_IDX_W+1:0]  r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_fault;
    logic [DEPTH_WORDS-1:0] r_written;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept, w_do_access;
    logic                w_a_we;
    logic [2:0]          w_a_f3;
    logic [c_IDX_W+1:0]  w_a_addr;
    logic [31:0]         w_a_wdata;
    logic [c_IDX_W-1:0]  w_idx;
    logic [1:0]          w_lane;
    logic                w_fault;
    logic [31:0]         w_base, w_merged, w_shift, w_load;
    logic                w_addr_unused;

    assign w_addr_unused = ^bus.req_addr[31:c_IDX_W+2];

    assign bus.req_ready = r_live && (r_state != ST_WAIT);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_do_access  = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_next_state = ST_WAIT;
                        w_cnt_next   = c_WAIT_LOAD;
                    end else begin
                        w_next_state = ST_RESP;
                        w_do_access  = 1'b1;
                    end
                end else if (r_state == ST_RESP) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                    w_do_access  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Zero-wait accesses happen on the acceptance edge, before the latch is loaded.
    assign w_a_we    = (r_state == ST_WAIT) ? r_we     : bus.req_we;
    assign w_a_f3    = (r_state == ST_WAIT) ? r_funct3 : bus.req_funct3;
    assign w_a_addr  = (r_state == ST_WAIT) ? r_addr   : bus.req_addr[c_IDX_W+1:0];
    assign w_a_wdata = (r_state == ST_WAIT) ? r_wdata  : bus.req_wdata;
    assign w_idx     = w_a_addr[c_IDX_W+1:2];
    assign w_lane    = w_a_addr[1:0];

    always_comb begin
        w_fault = 1'b0;
        case (w_a_f3)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = w_lane[0];
            3'b010:  w_fault = |w_lane;
            3'b100:  w_fault = w_a_we;
            3'b101:  w_fault = w_a_we | w_lane[0];
            default: w_fault = 1'b1;
        endcase
    end

    assign w_base  = r_written[w_idx] ? r_mem[w_idx] : 32'd0;
    assign w_shift = w_base >> {w_lane, 3'b000};

    always_comb begin
        w_merged = w_base;
        case (w_a_f3[1:0])
            2'b00:   w_merged[{w_lane, 3'b000} +: 8]      = w_a_wdata[7:0];
            2'b01:   w_merged[{w_lane[1], 4'b0000} +: 16] = w_a_wdata[15:0];
            default: w_merged = w_a_wdata;
        endcase
    end

    always_comb begin
        w_load = 32'd0;
        case (w_a_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = w_base;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_live      <= 1'b0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_fault <= 1'b0;
            r_written   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr[c_IDX_W+1:0];
                r_wdata  <= bus.req_wdata;
            end
            if (w_do_access) begin
                r_rsp_rdata <= (w_a_we || w_fault) ? 32'd0 : w_load;
                r_rsp_fault <= w_fault;
                if (w_a_we && !w_fault) begin
                    r_written[w_idx] <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset; the written flags mask stale contents instead.
    always_ff @(posedge clk) begin
        if (w_do_access && w_a_we && !w_fault) begin
            r_mem[w_idx] <= w_merged;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one zero-wait and one three-wait instance checked against
// a byte-addressed reference memory.
`default_nettype none

module tb_dmem_ctrl;
    localparam int c_DEPTH = 4096;
    localparam logic [31:0] c_BMASK = c_DEPTH * 4 - 1;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst3_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bit [7:0] mb0 [int];
    bit [7:0] mb3 [int];

    always #5 clk = ~clk;

    dmem_ctrl_if bus0 ();
    dmem_ctrl_if bus3 ();

    dmem_ctrl #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));
    dmem_ctrl #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic f_ready(input bit s3);  return s3 ? bus3.req_ready : bus0.req_ready; endfunction
    function automatic logic f_rvalid(input bit s3); return s3 ? bus3.rsp_valid : bus0.rsp_valid; endfunction
    function automatic logic [31:0] f_rdata(input bit s3); return s3 ? bus3.rsp_rdata : bus0.rsp_rdata; endfunction
    function automatic logic f_fault(input bit s3);  return s3 ? bus3.rsp_fault : bus0.rsp_fault; endfunction

    task automatic drive(input bit s3, input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (s3) begin
            bus3.req_valid = v; bus3.req_we = we; bus3.req_funct3 = f3;
            bus3.req_addr = a;  bus3.req_wdata = d;
        end else begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = a;  bus0.req_wdata = d;
        end
    endtask

    function automatic bit [7:0] rd_byte(input bit s3, input int idx);
        if (s3) return mb3.exists(idx) ? mb3[idx] : 8'h00;
        return mb0.exists(idx) ? mb0[idx] : 8'h00;
    endfunction

    function automatic void wr_byte(input bit s3, input int idx, input bit [7:0] val);
        if (s3) mb3[idx] = val;
        else    mb0[idx] = val;
    endfunction

    // Reference memory: flat byte array, unwritten bytes are zero.
    function automatic void model(input bit s3, input bit we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output bit flt);
        int n;
        bit legal;
        int base;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 <= 3'd2);
        else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        flt = !legal || ((a % n) != 0);
        rd = 32'd0;
        if (flt) return;
        base = int'(a & c_BMASK);
        if (we) begin
            for (int i = 0; i < n; i++) wr_byte(s3, base + i, 8'(d >> (8 * i)));
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(rd_byte(s3, base + i)) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
    endfunction

    task automatic issue(input bit s3, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int w = 0;
        drive(s3, 1'b1, we, f3, a, d);
        while (!f_ready(s3) && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 32'(w < 40), 32'd1);
        @(negedge clk);
        drive(s3, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic xact(input bit s3, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] erd;
        bit ef;
        int lat = 1;
        bit got = 1'b0;
        model(s3, we, f3, a, d, erd, ef);
        issue(s3, we, f3, a, d);
        for (int i = 0; i < 40 && !got; i++) begin
            if (f_rvalid(s3)) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", lat, s3 ? 32'd4 : 32'd1);
        check("rdata", f_rdata(s3), erd);
        check("fault", 32'(f_fault(s3)), 32'(ef));
        rd = f_rdata(s3);
        @(negedge clk);
    endtask

    task automatic reset_dut(input bit s3);
        if (s3) rst3_n = 1'b0; else rst0_n = 1'b0;
        #1;
        check("rst_ready", 32'(f_ready(s3)), 32'd0);
        check("rst_rvalid", 32'(f_rvalid(s3)), 32'd0);
        check("rst_rdata", f_rdata(s3), 32'd0);
        check("rst_fault", 32'(f_fault(s3)), 32'd0);
        if (s3) mb3.delete(); else mb0.delete();
        repeat (2) @(negedge clk);
        if (s3) rst3_n = 1'b1; else rst0_n = 1'b1;
        #1;
        check("rel_ready_low", 32'(f_ready(s3)), 32'd0);
        @(negedge clk);
        check("rel_ready_high", 32'(f_ready(s3)), 32'd1);
    endtask

    // Four loads with req_valid held high; checks spacing, data and ready gaps.
    task automatic burst(input bit s3);
        logic [31:0] addrs [4];
        logic [2:0]  f3s [4];
        int acc_q[$];
        logic [31:0] exp_q[$];
        int k = 0, rsp_n = 0, low_n = 0;
        int lat;
        logic [31:0] e;
        bit ef, acc;
        addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h11; addrs[3] = 32'h16;
        f3s[0] = 3'b010;   f3s[1] = 3'b010;   f3s[2] = 3'b000;   f3s[3] = 3'b101;
        lat = s3 ? 4 : 1;
        model(s3, 1'b0, f3s[0], addrs[0], 32'd0, e, ef);
        drive(s3, 1'b1, 1'b0, f3s[0], addrs[0], 32'd0);
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (f_rvalid(s3)) begin
                rsp_n++;
                if (acc_q.size() > 0) begin
                    check("burst_lat", cyc - acc_q.pop_front(), lat);
                    check("burst_rdata", f_rdata(s3), exp_q.pop_front());
                end
            end
            if (!f_ready(s3)) low_n++;
            acc = (k < 4) && f_ready(s3);
            if (acc) begin
                acc_q.push_back(cyc);
                exp_q.push_back(e);
            end
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 4) begin
                    model(s3, 1'b0, f3s[k], addrs[k], 32'd0, e, ef);
                    drive(s3, 1'b1, 1'b0, f3s[k], addrs[k], 32'd0);
                end else begin
                    drive(s3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
                end
            end
        end
        check("burst_rsp_count", rsp_n, 32'd4);
        check("burst_ready_low", low_n, s3 ? 32'd12 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int hi_n;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        reset_dut(1'b0);
        reset_dut(1'b1);

        xact(1'b0, 1'b0, 3'b010, 32'h0000, 32'd0, rd); check("zero_0", rd, 32'd0);
        xact(1'b0, 1'b0, 3'b010, 32'h07FC, 32'd0, rd); check("zero_7fc", rd, 32'd0);
        xact(1'b0, 1'b0, 3'b010, 32'hFFFC, 32'd0, rd); check("zero_fffc", rd, 32'd0);

        xact(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, rd);
        xact(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, rd);
        xact(1'b0, 1'b1, 3'b001, 32'h16, 32'h0000BEEF, rd);
        xact(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, rd); check("merge_lw10", rd, 32'h1122AA44);
        xact(1'b0, 1'b0, 3'b010, 32'h14, 32'd0, rd); check("merge_lw14", rd, 32'hBEEF0000);
        xact(1'b0, 1'b0, 3'b000, 32'h11, 32'd0, rd); check("merge_lb11", rd, 32'hFFFFFFAA);
        xact(1'b0, 1'b0, 3'b100, 32'h11, 32'd0, rd); check("merge_lbu11", rd, 32'h000000AA);
        xact(1'b0, 1'b0, 3'b001, 32'h16, 32'd0, rd); check("merge_lh16", rd, 32'hFFFFBEEF);
        repeat (3) @(negedge clk);
        check("rsp_hold", f_rdata(1'b0), 32'hFFFFBEEF);

        xact(1'b0, 1'b1, 3'b010, 32'h04, 32'h5A5A1234, rd);
        xact(1'b0, 1'b0, 3'b010, 32'h02, 32'd0, rd);
        xact(1'b0, 1'b1, 3'b001, 32'h05, 32'h0000FFFF, rd);
        xact(1'b0, 1'b0, 3'b011, 32'h08, 32'd0, rd);
        xact(1'b0, 1'b0, 3'b010, 32'h04, 32'd0, rd); check("fault_nowrite", rd, 32'h5A5A1234);

        xact(1'b0, 1'b1, 3'b010, 32'h4000, 32'hCAFEF00D, rd);
        xact(1'b0, 1'b0, 3'b010, 32'h0000, 32'd0, rd); check("alias", rd, 32'hCAFEF00D);

        burst(1'b0);

        xact(1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344, rd);
        xact(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, rd); check("ws3_lw10", rd, 32'h11223344);
        burst(1'b1);

        issue(1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
        @(negedge clk);
        reset_dut(1'b1);
        hi_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (f_rvalid(1'b1)) hi_n++;
            @(negedge clk);
        end
        check("abort_no_rsp", hi_n, 32'd0);
        xact(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, rd); check("abort_lw20", rd, 32'd0);
        xact(1'b1, 1'b1, 3'b010, 32'h24, 32'hDEADBEEF, rd);
        reset_dut(1'b1);
        xact(1'b1, 1'b0, 3'b010, 32'h24, 32'd0, rd); check("rst_clears_24", rd, 32'd0);

        for (int i = 0; i < 80; i++) begin
            bit s3, we;
            logic [2:0] f3;
            logic [31:0] a;
            s3 = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
            a = (32'($urandom_range(0, 3)) << 14) | 32'($urandom_range(0, 63));
            xact(s3, we, f3, a, $urandom, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
